dmem_responder: RTL

Multi-cycle data-memory target for the RV32I core's load/store path. Accepts one request at a time on a valid/ready request channel and returns read data plus an error flag on a valid/ready response channel. Storage is little-endian, byte-addressed and uses the core's DMCtrl width encoding. It replaces the zero-latency array so the core, or a later pipelined core, can be exercised against realistic memory latency and backpressure.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_lane_format.sv | 44 ++++
 rtl/dmem_responder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared width/sign encodings and FSM states for the data memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_ctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Access size in bytes; 0 marks an unassigned ctrl code.
    function automatic logic [2:0] ctrl_size(input logic [2:0] ctrl);
        case (ctrl)
            MEM_B, MEM_BU: ctrl_size = 3'd1;
            MEM_H, MEM_HU: ctrl_size = 3'd2;
            MEM_W:         ctrl_size = 3'd4;
            default:       ctrl_size = 3'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_format.sv
// ============================================================================
// Module   : dmem_lane_format
// Brief    : Extends raw little-endian bytes per ctrl and flags bad accesses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_lane_format
    import dmem_pkg::*;
(
    input  logic [2:0]      ctrl,
    input  logic [1:0]      addr,
    input  logic [3:0][7:0] raw,
    output logic [31:0]     rdata,
    output logic            misaligned,
    output logic            illegal
);

    always_comb begin
        rdata      = 32'h0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (ctrl)
            MEM_B:  rdata = {{24{raw[0][7]}}, raw[0]};
            MEM_BU: rdata = {24'h0, raw[0]};
            MEM_H: begin
                rdata      = {{16{raw[1][7]}}, raw[1], raw[0]};
                misaligned = addr[0];
            end
            MEM_HU: begin
                rdata      = {16'h0, raw[1], raw[0]};
                misaligned = addr[0];
            end
            MEM_W: begin
                rdata      = {raw[3], raw[2], raw[1], raw[0]};
                misaligned = (addr != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : Multi-cycle byte-addressed data memory with valid/ready channels.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_ctrl,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int       AW       = $clog2(DEPTH_BYTES);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_e     state, state_next;
    logic            lat_write;
    logic [2:0]      lat_ctrl;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_wdata;
    logic [3:0]      count;

    logic [7:0]      mem [DEPTH_BYTES];
    logic [AW-1:0]   idx [4];
    logic [3:0][7:0] raw;
    logic [31:0]     fmt_rdata;
    logic            misaligned, illegal, out_of_range;
    logic            access_err, access_now;
    logic [2:0]      size;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            assign idx[i] = lat_addr[AW-1:0] + AW'(i);
            assign raw[i] = mem[idx[i]];
        end
    endgenerate

    dmem_lane_format u_fmt (
        .ctrl       (lat_ctrl),
        .addr       (lat_addr[1:0]),
        .raw        (raw),
        .rdata      (fmt_rdata),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    assign size         = ctrl_size(lat_ctrl);
    assign out_of_range = ({1'b0, lat_addr} + 33'(size)) > 33'(DEPTH_BYTES);
    assign access_err   = illegal | misaligned | out_of_range | (lat_write & lat_ctrl[2]);
    assign access_now   = (state == WAIT) && (count == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = WAIT;
            end
            WAIT: if (count == 4'd0) state_next = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_write <= 1'b0;
            lat_ctrl  <= 3'b0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            count     <= 4'd0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_write <= req_write;
                lat_ctrl  <= req_ctrl;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                count     <= CNT_INIT;
            end
            if (state == WAIT && count != 4'd0) count <= count - 4'd1;
            if (access_now) begin
                rsp_rdata <= (access_err || lat_write) ? 32'h0 : fmt_rdata;
                rsp_err   <= access_err;
            end
        end
    end

    // Storage is not reset; the reset term blocks a store whose access edge coincides with reset.
    always_ff @(posedge clk) begin
        if (access_now && lat_write && !access_err && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(size)) mem[idx[i]] <= lat_wdata[8*i +: 8];
            end
        end
    end

endmodule

`default_nettype wire
